// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and default widths for the HUB75 framebuffer arbiter
package hub75_pkg;

    localparam int DEF_MEM_DATA_WIDTH = 18;
    localparam int DEF_MEM_ADDR_WIDTH = 4;
    localparam int DEF_WR_FIFO_DEPTH  = 4;

    // RAM address = {bank, word address}
    localparam int BANK_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SWAP  = 2'd2
    } swap_state_t;

endpackage

// File: rtl/hub75_wr_fifo.sv
// rtl/hub75_wr_fifo.sv - synchronous FIFO holding queued host writes {addr, data}
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  enqueue one entry (caller guarantees !full)
//   pop, pop_data    dequeue head; pop_data shows the head while !empty
//   full, empty      occupancy flags
module hub75_wr_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are power-of-two sized, so the natural wrap is the modulo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hub75_fb_arbiter.sv
// rtl/hub75_fb_arbiter.sv - double-buffered display RAM arbiter for a HUB75 panel driver
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   DRV_ADDR/DRV_RD       driver read of the front bank (highest priority)
//   DRV_DATA              read data, valid 2 cycles after the read is sampled
//   DRV_FRAME_DONE        driver end-of-frame pulse
//   HOST_WR_*             host write stream into the back bank (queued)
//   HOST_SWAP_REQ/ACK     host bank-swap handshake
//   FRONT_BANK            bank currently scanned by the driver
//   RAM_*                 registered single-port RAM interface
module hub75_fb_arbiter
    import hub75_pkg::*;
#(
    parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int WR_FIFO_DEPTH  = DEF_WR_FIFO_DEPTH
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [MEM_ADDR_WIDTH-1:0] DRV_ADDR,
    input  logic                      DRV_RD,
    output logic [MEM_DATA_WIDTH-1:0] DRV_DATA,
    input  logic                      DRV_FRAME_DONE,
    input  logic [MEM_ADDR_WIDTH-1:0] HOST_WR_ADDR,
    input  logic [MEM_DATA_WIDTH-1:0] HOST_WR_DATA,
    input  logic                      HOST_WR_VALID,
    output logic                      HOST_WR_READY,
    input  logic                      HOST_SWAP_REQ,
    output logic                      HOST_SWAP_ACK,
    output logic                      FRONT_BANK,
    output logic [MEM_ADDR_WIDTH:0]   RAM_ADDR,
    output logic [MEM_DATA_WIDTH-1:0] RAM_WDATA,
    output logic                      RAM_WE,
    input  logic [MEM_DATA_WIDTH-1:0] RAM_RDATA
);

    localparam int ENTRY_W = MEM_ADDR_WIDTH + MEM_DATA_WIDTH;

    swap_state_t               state_q;
    swap_state_t               state_d;
    logic                      front_q;
    logic                      run_q;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [ENTRY_W-1:0]        fifo_head;
    logic [MEM_ADDR_WIDTH-1:0] head_addr;
    logic [MEM_DATA_WIDTH-1:0] head_data;
    logic [MEM_ADDR_WIDTH:0]   ram_addr_q;
    logic [MEM_DATA_WIDTH-1:0] ram_wdata_q;
    logic                      ram_we_q;

    // run_q keeps READY low while reset is held and lets it rise one clock after release.
    assign HOST_WR_READY = run_q && !fifo_full && (state_q == ST_IDLE);
    assign fifo_push     = HOST_WR_VALID && HOST_WR_READY;
    // The driver owns the port whenever it reads; writes only fill the gaps.
    assign fifo_pop      = !DRV_RD && !fifo_empty;
    assign {head_addr, head_data} = fifo_head;

    hub75_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (WR_FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .push      (fifo_push),
        .push_data ({HOST_WR_ADDR, HOST_WR_DATA}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        HOST_SWAP_ACK = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (HOST_SWAP_REQ) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Swapping with writes still queued would expose a torn frame.
                if (fifo_empty && DRV_FRAME_DONE) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                HOST_SWAP_ACK = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            front_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            // The new bank takes effect for reads sampled after the SWAP cycle.
            if (state_q == ST_SWAP) begin
                front_q <= ~front_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
        end else if (DRV_RD) begin
            ram_addr_q <= {front_q, DRV_ADDR};
            ram_we_q   <= 1'b0;
        end else if (fifo_pop) begin
            ram_addr_q  <= {~front_q, head_addr};
            ram_wdata_q <= head_data;
            ram_we_q    <= 1'b1;
        end else begin
            ram_we_q <= 1'b0;
        end
    end

    assign RAM_ADDR   = ram_addr_q;
    assign RAM_WDATA  = ram_wdata_q;
    assign RAM_WE     = ram_we_q;
    assign FRONT_BANK = front_q;
    assign DRV_DATA   = RAM_RDATA;

endmodule
